// File: rtl/rfile_port_arbiter.sv
// rfile_port_arbiter: shares the rfile port between core and debug, one transaction per cycle.
// Optional `define RFILE_ARB_LOCK_EN adds dbg_lock and the DBG_LOCKED state.
module rfile_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 32,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req,
  input  logic [4:0]           core_rs1_addr,
  input  logic [4:0]           core_rs2_addr,
  input  logic                 core_we,
  input  logic [4:0]           core_rd,
  input  logic [DATA_W-1:0]    core_wdata,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [DATA_W-1:0]    core_rs1_data,
  output logic [DATA_W-1:0]    core_rs2_data,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [4:0]           dbg_addr,
  input  logic [DATA_W-1:0]    dbg_wdata,
`ifdef RFILE_ARB_LOCK_EN
  input  logic                 dbg_lock,
`endif
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [DATA_W-1:0]    dbg_rdata,
  output logic [RF_ADDR_W-1:0] rf_rs1_addr,
  output logic [RF_ADDR_W-1:0] rf_rs2_addr,
  output logic [RF_ADDR_W-1:0] rf_rd,
  output logic                 rf_read_rs1,
  output logic                 rf_read_rs2,
  output logic                 rf_rd_write,
  output logic [DATA_W-1:0]    rf_rd_data,
  input  logic [DATA_W-1:0]    rf_rs1,
  input  logic [DATA_W-1:0]    rf_rs2
);
  typedef enum logic {ARB, DBG_LOCKED} state_t;
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
  state_t     state;
  logic [3:0] wait_cnt;
  logic       core_rv, dbg_rv;
  logic       locked, dbg_win, core_win, dbg_rd, dbg_wr;
  // Every combinational output is gated by reset so nothing leaks while it is held low.
  always_comb begin
    locked        = reset && state == DBG_LOCKED;
    dbg_win       = reset && dbg_req && (wait_cnt == MAX_CNT || locked || !core_req);
    core_win      = reset && core_req && !dbg_win && !locked;
    dbg_rd        = dbg_win && !dbg_we;
    dbg_wr        = dbg_win && dbg_we;
    core_gnt      = core_win;
    dbg_gnt       = dbg_win;
    rf_read_rs1   = core_win || dbg_rd;
    rf_read_rs2   = core_win;
    rf_rs1_addr   = core_win ? RF_ADDR_W'(core_rs1_addr) : dbg_rd ? RF_ADDR_W'(dbg_addr) : '0;
    rf_rs2_addr   = core_win ? RF_ADDR_W'(core_rs2_addr) : '0;
    rf_rd_write   = core_win ? core_we && core_rd != '0 : dbg_wr && dbg_addr != '0;
    rf_rd         = core_win ? RF_ADDR_W'(core_rd) : dbg_wr ? RF_ADDR_W'(dbg_addr) : '0;
    rf_rd_data    = core_win ? core_wdata : dbg_wr ? dbg_wdata : '0;
    core_rvalid   = reset && core_rv;
    dbg_rvalid    = reset && dbg_rv;
    core_rs1_data = core_rvalid ? rf_rs1 : '0;
    core_rs2_data = core_rvalid ? rf_rs2 : '0;
    dbg_rdata     = dbg_rvalid ? rf_rs1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB;
      wait_cnt <= '0;
      core_rv  <= 1'b0;
      dbg_rv   <= 1'b0;
    end else begin
      core_rv  <= core_win;
      dbg_rv   <= dbg_rd;
      wait_cnt <= (!dbg_req || dbg_win || locked) ? '0 : wait_cnt == MAX_CNT ? MAX_CNT : wait_cnt + 4'd1;
`ifdef RFILE_ARB_LOCK_EN
      state    <= (locked || dbg_win) && dbg_lock ? DBG_LOCKED : ARB;
`else
      state    <= ARB;
`endif
    end
  end
endmodule
